aes128_share_io: RTL and testbench
==================================

# aes128_share_io

Word-serial share loader and unloader placed directly upstream and downstream of the masked AES-128 wrapper. It assembles the d-share plaintext and key buses from a narrow W-bit input stream and launches one encryption through the core's valid_in/ready handshake. It then captures the shared ciphertext on cipher_valid and streams it back out W bits at a time. It holds one block in flight; no shares are ever recombined.

## Interface
- d, default 2: number of shares; each bus is 128*d bits.
- W, default 32: stream word width; must be one of 8, 16, 32, 64, 128 (W divides 128).
- clk  in  1  clock, all state on rising edge.
- nrst  in  1  reset, asynchronous and active-low.
- in_data  in  W  input word.
- in_valid  in  1  input word valid.
- in_ready  out  1  loader accepts a word this cycle.
- out_data  out  W  ciphertext share word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts out_data.
- busy  out  1  high in any state other than LOAD.
- core_valid_in  out  1  to core valid_in.
- core_ready  in  1  from core ready.
- core_cipher_valid  in  1  from core cipher_valid.
- core_sh_plaintext  out  128*d  to core, registered.
- core_sh_key  out  128*d  to core, registered.
- core_sh_ciphertext  in  128*d  from core.

## Operation
- NI = 256*d/W input words per block; NO = 128*d/W output words per block.
- Input word i (0-based) is written to bits [W*i +: W] of the concatenation {key buffer, plaintext buffer}:
  - words 0..NI/2-1 fill core_sh_plaintext from the LSB.
  - words NI/2..NI-1 fill core_sh_key from the LSB.
- Output word j = captured ciphertext bits [W*j +: W].
- FSM states:
  - LOAD: in_ready=1. Each in_valid&in_ready writes one word and increments the counter. Acceptance of word NI-1 moves to START and clears the counter.
  - START: core_valid_in=1. A cycle with core_ready=1 moves to WAIT.
  - WAIT: core_valid_in=0. The first cycle with core_cipher_valid=1 registers core_sh_ciphertext and moves to DRAIN.
  - DRAIN: out_valid=1. Each out_valid&out_ready increments the counter. Acceptance of word NO-1 moves to LOAD and clears the counter.
- One shared counter, width clog2(NI); never wraps past its terminal value.
- Plaintext and key buffers stay stable from START until the next LOAD write. The core may sample them at any point.
- core_cipher_valid outside WAIT is ignored.
- in_valid outside LOAD is ignored; the word is not consumed.
- out_ready outside DRAIN is ignored.

## Timing
- Reset, async assert: state=LOAD, counter=0, all buffers zeroed. Outputs during reset: in_ready=1, out_valid=0, core_valid_in=0, busy=0, out_data=0, core buses=0.
- Reset mid-operation aborts the block; a partially loaded or undrained block is discarded.
- Back-to-back input (in_valid held high): word per cycle; START asserted the cycle after the last word.
- core_valid_in asserted in START, dropped the cycle after the handshake. Held high indefinitely while core_ready=0.
- Capture: out_valid rises the cycle after core_cipher_valid is seen in WAIT, presenting word 0.
- out_data stable while out_valid&!out_ready.
- After the last output handshake, in_ready=1 the next cycle.
- Minimum overhead around core latency: NI + 1 (START with ready) + 1 (capture) + NO cycles.

## Test plan
- Load, d=2, W=32: reset, send 16 words 32'h10000000+i back-to-back. Expect:
  - core_sh_plaintext[31:0]=32'h10000000 and core_sh_key[255:224]=32'h1000000F.
  - core_valid_in high the cycle after word 15.
- Stalled launch: core_ready=0 for 5 cycles then 1. Expect:
  - core_valid_in high for all 6 cycles, low the next.
  - busy high throughout.
  - in_ready=0 throughout.
- Capture/drain: core returns ciphertext words 32'hC0000000+j with a one-cycle core_cipher_valid pulse. Expect:
  - out_valid the next cycle.
  - 8 words C0000000..C0000007 in order.
  - in_ready=1 the cycle after word 7.
- Out backpressure: toggle out_ready 1,0,0,1... Expect out_data held during low cycles and no word dropped or duplicated.
- Spurious events: pulse core_cipher_valid during LOAD and drive in_valid during DRAIN. Expect no capture, no counter change, and correct next block.
- Mid-block reset: assert nrst=0 after 7 input words. Expect:
  - immediate in_ready=1, busy=0, zeroed buses.
  - a fresh 16-word load proceeds correctly.

Source files
------------

// File: rtl/aes128_share_io_if.sv
// Stream and core-side handshake bundle for the AES-128 share loader/unloader.
// slave is the loader's view; master is the environment's view.
interface aes128_share_io_if #(
  parameter int unsigned d = 2,
  parameter int unsigned W = 32
);
  logic [W-1:0]       in_data;
  logic               in_valid;
  logic               in_ready;
  logic [W-1:0]       out_data;
  logic               out_valid;
  logic               out_ready;
  logic               busy;
  logic               core_valid_in;
  logic               core_ready;
  logic               core_cipher_valid;
  logic [128*d-1:0]   core_sh_plaintext;
  logic [128*d-1:0]   core_sh_key;
  logic [128*d-1:0]   core_sh_ciphertext;

  modport slave (
    input  in_data, in_valid, out_ready, core_ready, core_cipher_valid, core_sh_ciphertext,
    output in_ready, out_data, out_valid, busy, core_valid_in, core_sh_plaintext, core_sh_key
  );

  modport master (
    output in_data, in_valid, out_ready, core_ready, core_cipher_valid, core_sh_ciphertext,
    input  in_ready, out_data, out_valid, busy, core_valid_in, core_sh_plaintext, core_sh_key
  );
endinterface

// File: rtl/aes128_share_io.sv
// Word-serial loader of d-share plaintext/key and unloader of shared ciphertext around a
// masked AES-128 core; one block in flight, shares are never recombined.
module aes128_share_io #(
  parameter int unsigned d = 2,
  parameter int unsigned W = 32
) (
  input  logic              clk,
  input  logic              nrst,
  aes128_share_io_if.slave  bus
);

  localparam int unsigned NI = 256 * d / W;
  localparam int unsigned NO = 128 * d / W;
  localparam int unsigned CW = $clog2(NI);

  typedef enum logic [1:0] {StLoad, StStart, StWait, StDrain} state_e;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [256*d-1:0] r_in_buf;
  logic [128*d-1:0] r_ct;
  logic [256*d-1:0] w_ct_ext;
  logic             w_in_acc;
  logic             w_out_acc;
  logic             w_in_last;
  logic             w_out_last;
  logic             w_capture;

  assign w_in_acc   = (r_state == StLoad) && bus.in_valid;
  assign w_out_acc  = (r_state == StDrain) && bus.out_ready;
  assign w_in_last  = (r_cnt == CW'(NI - 1));
  assign w_out_last = (r_cnt == CW'(NO - 1));
  assign w_capture  = (r_state == StWait) && bus.core_cipher_valid;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= StLoad;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StLoad:  if (w_in_acc && w_in_last) w_state_nxt = StStart;
      StStart: if (bus.core_ready) w_state_nxt = StWait;
      StWait:  if (bus.core_cipher_valid) w_state_nxt = StDrain;
      StDrain: if (w_out_acc && w_out_last) w_state_nxt = StLoad;
      default: w_state_nxt = StLoad;
    endcase
  end

  always_comb begin
    bus.in_ready      = 1'b0;
    bus.core_valid_in = 1'b0;
    bus.out_valid     = 1'b0;
    bus.busy          = 1'b1;
    case (r_state)
      StLoad: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b0;
      end
      StStart: bus.core_valid_in = 1'b1;
      StWait:  ;
      StDrain: bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  // Shared word counter: input words in LOAD, output words in DRAIN.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_cnt <= '0;
    end else if (w_in_acc) begin
      r_cnt <= w_in_last ? '0 : r_cnt + 1'b1;
    end else if (w_out_acc) begin
      r_cnt <= w_out_last ? '0 : r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_in_buf <= '0;
      r_ct     <= '0;
    end else begin
      if (w_in_acc) begin
        r_in_buf[W*r_cnt +: W] <= bus.in_data;
      end
      if (w_capture) begin
        r_ct <= bus.core_sh_ciphertext;
      end
    end
  end

  // Zero-padded so the counter can index it over its full range without leaving the vector.
  assign w_ct_ext = {{(128*d){1'b0}}, r_ct};

  assign bus.out_data          = w_ct_ext[W*r_cnt +: W];
  assign bus.core_sh_plaintext = r_in_buf[128*d-1:0];
  assign bus.core_sh_key       = r_in_buf[256*d-1:128*d];

endmodule

// File: tb/tb_aes128_share_io.sv
// Directed bench for aes128_share_io at d=2, W=32: load, stalled launch, capture, drain,
// output backpressure, ignored out-of-state events and mid-block reset.
module tb_aes128_share_io;

  logic clk = 1'b0;
  logic nrst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  aes128_share_io_if #(.d(2), .W(32)) u_if ();

  aes128_share_io #(.d(2), .W(32)) u_dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (u_if.slave)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_words(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      u_if.in_valid = 1'b1;
      u_if.in_data  = base + i;
      check("in_ready_load", u_if.in_ready, 1'b1);
      step();
    end
    u_if.in_valid = 1'b0;
    u_if.in_data  = '0;
  endtask

  task automatic check_bufs(input logic [31:0] base);
    logic [255:0] exp_pt;
    logic [255:0] exp_key;
    for (int i = 0; i < 8; i++) begin
      exp_pt[32*i +: 32]  = base + i;
      exp_key[32*i +: 32] = base + 8 + i;
    end
    check("plaintext_bus", u_if.core_sh_plaintext, exp_pt);
    check("key_bus", u_if.core_sh_key, exp_key);
  endtask

  task automatic launch(input int stall, input bit spurious);
    for (int k = 0; k <= stall; k++) begin
      u_if.core_ready = (k == stall);
      if (spurious) begin
        u_if.in_valid = 1'b1;
        u_if.in_data  = 32'hDEADBEEF;
      end
      check("core_valid_in_start", u_if.core_valid_in, 1'b1);
      check("busy_start", u_if.busy, 1'b1);
      check("in_ready_start", u_if.in_ready, 1'b0);
      step();
    end
    u_if.core_ready = 1'b0;
    u_if.in_valid   = 1'b0;
    check("core_valid_in_dropped", u_if.core_valid_in, 1'b0);
  endtask

  task automatic capture(input logic [31:0] base, input int wait_cycles);
    logic [255:0] ct;
    for (int j = 0; j < 8; j++) ct[32*j +: 32] = base + j;
    for (int k = 0; k < wait_cycles; k++) begin
      check("out_valid_wait", u_if.out_valid, 1'b0);
      check("busy_wait", u_if.busy, 1'b1);
      step();
    end
    u_if.core_sh_ciphertext = ct;
    u_if.core_cipher_valid  = 1'b1;
    step();
    u_if.core_cipher_valid  = 1'b0;
    u_if.core_sh_ciphertext = '1;
    check("out_valid_after_capture", u_if.out_valid, 1'b1);
  endtask

  task automatic drain(input logic [31:0] base, input bit bp, input bit spurious);
    int  j = 0;
    int  cyc = 0;
    bit  rdy;
    while (j < 8 && cyc < 64) begin
      rdy = bp ? (cyc % 3 == 0) : 1'b1;
      u_if.out_ready = rdy;
      if (spurious) begin
        u_if.in_valid = 1'b1;
        u_if.in_data  = 32'hFFFFFFFF;
      end
      check("out_valid_drain", u_if.out_valid, 1'b1);
      check("out_data", u_if.out_data, base + j);
      step();
      if (rdy) j++;
      cyc++;
    end
    u_if.out_ready = 1'b0;
    u_if.in_valid  = 1'b0;
    check("drain_word_count", j, 8);
    check("in_ready_after_drain", u_if.in_ready, 1'b1);
    check("out_valid_after_drain", u_if.out_valid, 1'b0);
    check("busy_after_drain", u_if.busy, 1'b0);
  endtask

  initial begin
    nrst                    = 1'b0;
    u_if.in_data            = '0;
    u_if.in_valid           = 1'b0;
    u_if.out_ready          = 1'b0;
    u_if.core_ready         = 1'b0;
    u_if.core_cipher_valid  = 1'b0;
    u_if.core_sh_ciphertext = '0;
    #3;
    check("rst_in_ready", u_if.in_ready, 1'b1);
    check("rst_out_valid", u_if.out_valid, 1'b0);
    check("rst_core_valid_in", u_if.core_valid_in, 1'b0);
    check("rst_busy", u_if.busy, 1'b0);
    check("rst_out_data", u_if.out_data, 32'h0);
    check("rst_plaintext", u_if.core_sh_plaintext, 256'h0);
    check("rst_key", u_if.core_sh_key, 256'h0);
    step();
    nrst = 1'b1;
    step();

    // Block 1: back-to-back load, stalled launch with ignored input, plain drain.
    load_words(32'h10000000, 16);
    check("start_after_last_word", u_if.core_valid_in, 1'b1);
    check("pt_word0", u_if.core_sh_plaintext[31:0], 32'h10000000);
    check("key_word7", u_if.core_sh_key[255:224], 32'h1000000F);
    check_bufs(32'h10000000);
    launch(5, 1'b1);
    check_bufs(32'h10000000);
    capture(32'hC0000000, 3);
    drain(32'hC0000000, 1'b0, 1'b0);

    // Block 2: cipher_valid pulse in LOAD must be ignored; backpressured drain with in_valid.
    u_if.core_sh_ciphertext = {8{32'h55555555}};
    u_if.core_cipher_valid  = 1'b1;
    step();
    u_if.core_cipher_valid  = 1'b0;
    check("spurious_cv_busy", u_if.busy, 1'b0);
    check("spurious_cv_in_ready", u_if.in_ready, 1'b1);
    load_words(32'h20000000, 16);
    check("start_block2", u_if.core_valid_in, 1'b1);
    check_bufs(32'h20000000);
    launch(0, 1'b0);
    capture(32'hD0000000, 0);
    drain(32'hD0000000, 1'b1, 1'b1);
    check_bufs(32'h20000000);

    // Block 3: reset after 7 words discards the partial block.
    load_words(32'h30000000, 7);
    nrst = 1'b0;
    #1;
    check("midrst_in_ready", u_if.in_ready, 1'b1);
    check("midrst_busy", u_if.busy, 1'b0);
    check("midrst_plaintext", u_if.core_sh_plaintext, 256'h0);
    check("midrst_key", u_if.core_sh_key, 256'h0);
    step();
    nrst = 1'b1;
    step();
    load_words(32'h40000000, 16);
    check("start_block4", u_if.core_valid_in, 1'b1);
    check_bufs(32'h40000000);
    launch(1, 1'b0);
    capture(32'hE0000000, 1);
    drain(32'hE0000000, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
